// File: rtl/uart_tx_feeder_pkg.sv
// Shared types and widths for the UART transmit path.
package uart_tx_feeder_pkg;

    localparam int unsigned UART_DATA_W = 8;
    localparam int unsigned FIFO_DEPTH  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SENT = 2'd1,
        WAIT = 2'd2
    } tx_state_t;

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Producer write port plus transmitter start/data/busy handshake.
interface uart_tx_feeder_if
    import uart_tx_feeder_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH
) ();

    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic                   wr_en;
    logic [UART_DATA_W-1:0] wr_data;
    logic                   full;
    logic                   empty;
    logic [ADDR_W:0]        count;
    logic                   overflow;
    logic                   TxD_start;
    logic [UART_DATA_W-1:0] TxD_data;
    logic                   TxD_busy;

    modport master (
        output wr_en, wr_data, TxD_busy,
        input  full, empty, count, overflow, TxD_start, TxD_data
    );

    modport slave (
        input  wr_en, wr_data, TxD_busy,
        output full, empty, count, overflow, TxD_start, TxD_data
    );

endinterface

// File: rtl/uart_tx_feeder_fifo.sv
// Byte FIFO with registered read data; a pop frees a slot for a same-cycle push.
module uart_byte_fifo
    import uart_tx_feeder_pkg::*;
#(
    parameter  int unsigned DEPTH  = FIFO_DEPTH,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [UART_DATA_W-1:0] data_i,
    output logic [UART_DATA_W-1:0] data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [ADDR_W:0]        count_o,
    output logic                   overflow_o
);

    logic [UART_DATA_W-1:0] mem_q [DEPTH];
    logic [UART_DATA_W-1:0] data_q;
    logic [ADDR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]        count_q, count_d;
    logic                   full_q, empty_q, overflow_q;
    logic                   push_ok_c, pop_ok_c;

    always_comb begin
        pop_ok_c  = pop_i & ~empty_q;
        push_ok_c = push_i & (~full_q | pop_ok_c);
        wr_ptr_d  = push_ok_c ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d  = pop_ok_c  ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
        count_d   = count_q + (ADDR_W+1)'(push_ok_c) - (ADDR_W+1)'(pop_ok_c);
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            data_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= (count_d == (ADDR_W+1)'(DEPTH));
            empty_q    <= (count_d == '0);
            overflow_q <= push_i & full_q & ~pop_ok_c;
            if (pop_ok_c) begin
                data_q <= mem_q[rd_ptr_q];
            end
        end
    end

    assign data_o     = data_q;
    assign full_o     = full_q;
    assign empty_o    = empty_q;
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// Drains the byte FIFO into the async transmitter, one launch per idle transmitter.
module uart_tx_feeder
    import uart_tx_feeder_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH
) (
    input  logic             FPGA_CLK1_50,
    input  logic             reset_n,
    uart_tx_feeder_if.slave  bus
);

    tx_state_t state_q, state_d;
    logic      launch_c;
    logic      start_q;

    // Popped head lands in the FIFO read register, which is TxD_data itself.
    uart_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (FPGA_CLK1_50),
        .rst_n      (reset_n),
        .push_i     (bus.wr_en),
        .pop_i      (launch_c),
        .data_i     (bus.wr_data),
        .data_o     (bus.TxD_data),
        .full_o     (bus.full),
        .empty_o    (bus.empty),
        .count_o    (bus.count),
        .overflow_o (bus.overflow)
    );

    // SENT covers the cycle where busy has not yet risen after a launch.
    always_comb begin
        state_d  = state_q;
        launch_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (!bus.empty && !bus.TxD_busy) begin
                    launch_c = 1'b1;
                    state_d  = SENT;
                end
            end
            SENT: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (!bus.TxD_busy) begin
                    if (!bus.empty) begin
                        launch_c = 1'b1;
                        state_d  = SENT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge FPGA_CLK1_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= launch_c;
        end
    end

    assign bus.TxD_start = start_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a frame-length busy model of the transmitter.
module tb_uart_tx_feeder;
    import uart_tx_feeder_pkg::*;

    localparam int unsigned DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_tx_feeder_if #(.DEPTH(DEPTH)) bus ();

    uart_tx_feeder #(.DEPTH(DEPTH)) dut (
        .FPGA_CLK1_50 (clk),
        .reset_n      (rst_n),
        .bus          (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Transmitter model: busy from the cycle after start is sampled, for frame_len cycles.
    logic busy_hold = 1'b0;
    int   frame_len = 6;
    int   frame_cnt = 0;
    assign bus.TxD_busy = busy_hold | (frame_cnt != 0);

    always @(posedge clk) begin
        if (bus.TxD_start === 1'b1) frame_cnt <= frame_len;
        else if (frame_cnt != 0)    frame_cnt <= frame_cnt - 1;
    end

    logic [7:0] tx_log[$];
    int         gap_log[$];
    int         cyc = 0;
    int         last_busy = -100;
    int         viol = 0;
    logic       prev_start = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (bus.TxD_start === 1'b1) begin
            tx_log.push_back(bus.TxD_data);
            gap_log.push_back(cyc - last_busy);
            if (bus.TxD_busy || prev_start) viol++;
        end
        if (bus.TxD_busy) last_busy = cyc;
        prev_start = bus.TxD_start;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string tag);
        int quiet = 0;
        for (int i = 0; i < 2000 && quiet < 3; i++) begin
            tick();
            if (bus.empty && !bus.TxD_busy && !bus.TxD_start) quiet++;
            else quiet = 0;
        end
        n_vec++;
        if (quiet < 3) begin n_err++; $display("FAIL %s_drain_timeout: count=%0d busy=%0b", tag, bus.count, bus.TxD_busy); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.wr_en = 1'b0; bus.wr_data = 8'h00; busy_hold = 1'b0; frame_len = 6;
        repeat (3) tick();
        n_vec++; if (bus.count !== 5'd0)     begin n_err++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        n_vec++; if (bus.empty !== 1'b1)     begin n_err++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
        n_vec++; if (bus.full !== 1'b0)      begin n_err++; $display("FAIL reset_full: got %b want 0", bus.full); end
        n_vec++; if (bus.overflow !== 1'b0)  begin n_err++; $display("FAIL reset_overflow: got %b want 0", bus.overflow); end
        n_vec++; if (bus.TxD_start !== 1'b0) begin n_err++; $display("FAIL reset_start: got %b want 0", bus.TxD_start); end
        n_vec++; if (bus.TxD_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", bus.TxD_data); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int base = tx_log.size();
        bus.wr_en = 1'b1; bus.wr_data = 8'hA5;
        tick();
        bus.wr_en = 1'b0;
        n_vec++; if (bus.TxD_start !== 1'b0) begin n_err++; $display("FAIL single_start_k1: got %b want 0", bus.TxD_start); end
        n_vec++; if (bus.count !== 5'd1)     begin n_err++; $display("FAIL single_count_k1: got %0d want 1", bus.count); end
        tick();
        n_vec++; if (bus.TxD_start !== 1'b1) begin n_err++; $display("FAIL single_start_k2: got %b want 1", bus.TxD_start); end
        n_vec++; if (bus.TxD_data !== 8'hA5) begin n_err++; $display("FAIL single_data: got %h want a5", bus.TxD_data); end
        n_vec++; if (bus.empty !== 1'b1)     begin n_err++; $display("FAIL single_empty: got %b want 1", bus.empty); end
        tick();
        n_vec++; if (bus.TxD_start !== 1'b0) begin n_err++; $display("FAIL single_start_width: got %b want 0", bus.TxD_start); end
        n_vec++; if (bus.TxD_data !== 8'hA5) begin n_err++; $display("FAIL single_data_hold: got %h want a5", bus.TxD_data); end
        wait_drain("single");
        n_vec++; if (tx_log.size() !== base + 1) begin n_err++; $display("FAIL single_launches: got %0d want 1", tx_log.size() - base); end
    endtask

    task automatic test_burst();
        int base  = tx_log.size();
        int vbase = viol;
        int peak  = 0;
        frame_len = 6;
        for (int i = 0; i < 5; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = 8'(i + 1);
            tick();
            if (int'(bus.count) > peak) peak = int'(bus.count);
        end
        bus.wr_en = 1'b0;
        wait_drain("burst");
        n_vec++; if (peak !== 4) begin n_err++; $display("FAIL burst_peak_count: got %0d want 4", peak); end
        n_vec++; if (tx_log.size() !== base + 5) begin n_err++; $display("FAIL burst_launches: got %0d want 5", tx_log.size() - base); end
        for (int i = 0; i < 5 && base + i < tx_log.size(); i++) begin
            n_vec++; if (tx_log[base+i] !== 8'(i + 1)) begin n_err++; $display("FAIL burst_order[%0d]: got %h want %h", i, tx_log[base+i], 8'(i + 1)); end
        end
        for (int i = 1; i < 5 && base + i < gap_log.size(); i++) begin
            n_vec++; if (gap_log[base+i] !== 2) begin n_err++; $display("FAIL burst_b2b_gap[%0d]: got %0d want 2", i, gap_log[base+i]); end
        end
        n_vec++; if (viol !== vbase) begin n_err++; $display("FAIL burst_start_while_busy: got %0d want %0d", viol, vbase); end
    endtask

    task automatic test_full_overflow();
        int base = tx_log.size();
        int ovf  = 0;
        busy_hold = 1'b1;
        for (int i = 0; i < 18; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = 8'(8'h10 + i);
            tick();
            if (bus.overflow) ovf++;
        end
        bus.wr_en = 1'b0;
        tick();
        if (bus.overflow) ovf++;
        n_vec++; if (bus.full !== 1'b1)     begin n_err++; $display("FAIL full_flag: got %b want 1", bus.full); end
        n_vec++; if (bus.count !== 5'd16)   begin n_err++; $display("FAIL full_count: got %0d want 16", bus.count); end
        n_vec++; if (ovf !== 2)             begin n_err++; $display("FAIL overflow_pulses: got %0d want 2", ovf); end
        n_vec++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL overflow_clear: got %b want 0", bus.overflow); end
        n_vec++; if (tx_log.size() !== base) begin n_err++; $display("FAIL full_no_launch: got %0d want 0", tx_log.size() - base); end
    endtask

    task automatic test_write_pop_full();
        int base = tx_log.size();
        busy_hold = 1'b0;
        bus.wr_en = 1'b1; bus.wr_data = 8'h30;
        tick();
        bus.wr_en = 1'b0;
        n_vec++; if (bus.count !== 5'd16)    begin n_err++; $display("FAIL wrpop_count: got %0d want 16", bus.count); end
        n_vec++; if (bus.full !== 1'b1)      begin n_err++; $display("FAIL wrpop_full: got %b want 1", bus.full); end
        n_vec++; if (bus.overflow !== 1'b0)  begin n_err++; $display("FAIL wrpop_overflow: got %b want 0", bus.overflow); end
        n_vec++; if (bus.TxD_start !== 1'b1) begin n_err++; $display("FAIL wrpop_start: got %b want 1", bus.TxD_start); end
        n_vec++; if (bus.TxD_data !== 8'h10) begin n_err++; $display("FAIL wrpop_data: got %h want 10", bus.TxD_data); end
        wait_drain("wrpop");
        n_vec++; if (tx_log.size() !== base + 17) begin n_err++; $display("FAIL wrpop_launches: got %0d want 17", tx_log.size() - base); end
        for (int i = 0; i < 17 && base + i < tx_log.size(); i++) begin
            logic [7:0] exp_b;
            exp_b = (i < 16) ? 8'(8'h10 + i) : 8'h30;
            n_vec++; if (tx_log[base+i] !== exp_b) begin n_err++; $display("FAIL wrpop_order[%0d]: got %h want %h", i, tx_log[base+i], exp_b); end
        end
    endtask

    task automatic test_reset_mid();
        int base;
        busy_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = 8'(8'h41 + i);
            tick();
        end
        bus.wr_en = 1'b0;
        n_vec++; if (bus.count !== 5'd3) begin n_err++; $display("FAIL rstmid_pre_count: got %0d want 3", bus.count); end
        rst_n = 1'b0;
        tick();
        n_vec++; if (bus.count !== 5'd0)     begin n_err++; $display("FAIL rstmid_count: got %0d want 0", bus.count); end
        n_vec++; if (bus.empty !== 1'b1)     begin n_err++; $display("FAIL rstmid_empty: got %b want 1", bus.empty); end
        n_vec++; if (bus.TxD_start !== 1'b0) begin n_err++; $display("FAIL rstmid_start: got %b want 0", bus.TxD_start); end
        n_vec++; if (bus.TxD_data !== 8'h00) begin n_err++; $display("FAIL rstmid_data: got %h want 00", bus.TxD_data); end
        rst_n = 1'b1;
        base = tx_log.size();
        bus.wr_en = 1'b1; bus.wr_data = 8'h77;
        tick();
        bus.wr_en = 1'b0;
        repeat (5) tick();
        n_vec++; if (tx_log.size() !== base) begin n_err++; $display("FAIL rstmid_held: got %0d launches want 0", tx_log.size() - base); end
        n_vec++; if (bus.count !== 5'd1)     begin n_err++; $display("FAIL rstmid_queued: got %0d want 1", bus.count); end
        busy_hold = 1'b0;
        tick();
        n_vec++; if (bus.TxD_start !== 1'b1) begin n_err++; $display("FAIL rstmid_launch: got %b want 1", bus.TxD_start); end
        n_vec++; if (bus.TxD_data !== 8'h77) begin n_err++; $display("FAIL rstmid_launch_data: got %h want 77", bus.TxD_data); end
        wait_drain("rstmid");
        n_vec++; if (tx_log.size() !== base + 1) begin n_err++; $display("FAIL rstmid_launches: got %0d want 1", tx_log.size() - base); end
    endtask

    task automatic test_wrap();
        int base  = tx_log.size();
        int vbase = viol;
        int ovf   = 0;
        frame_len = 2;
        for (int b = 0; b < 40; b++) begin
            repeat ($urandom_range(0, 2)) tick();
            for (int w = 0; w < 200 && bus.full; w++) tick();
            bus.wr_en = 1'b1; bus.wr_data = 8'(b);
            tick();
            bus.wr_en = 1'b0;
            if (bus.overflow) ovf++;
        end
        wait_drain("wrap");
        n_vec++; if (ovf !== 0) begin n_err++; $display("FAIL wrap_overflow: got %0d want 0", ovf); end
        n_vec++; if (tx_log.size() !== base + 40) begin n_err++; $display("FAIL wrap_launches: got %0d want 40", tx_log.size() - base); end
        for (int b = 0; b < 40 && base + b < tx_log.size(); b++) begin
            n_vec++; if (tx_log[base+b] !== 8'(b)) begin n_err++; $display("FAIL wrap_order[%0d]: got %h want %h", b, tx_log[base+b], 8'(b)); end
        end
        n_vec++; if (viol !== vbase) begin n_err++; $display("FAIL wrap_start_while_busy: got %0d want %0d", viol, vbase); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_full_overflow();
        test_write_pop_full();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
